// File: rtl/spell_stack_engine.sv
// Parametrised operand stack with a pop-N/push-M command port, sticky
// overflow/underflow flags with interrupt, and a Wishbone debug slave.
module spell_stack_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_pop,
    input  logic [1:0]       cmd_push,
    input  logic [WIDTH-1:0] cmd_top,
    input  logic [WIDTH-1:0] cmd_below,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] below,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             irq,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [31:0]      i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       flags;
    logic [1:0]       int_en;
    logic [31:0]      peek_ix;
    logic             prev_stb;

    logic             wb_stb, wb_wr, wb_rd, wb_push, cmd_go;
    logic [7:0]       reg_addr;
    logic [DW:0]      depth_ext, new_depth;
    logic             underflow, overflow;
    logic [1:0]       flag_set, flag_clr;
    logic [DW-1:0]    depth_wr;
    logic [WIDTH-1:0] peek_val;
    logic [31:0]      rd_data;
    logic             unused_addr;

    assign unused_addr = ^i_wb_addr[31:8];
    assign reg_addr    = i_wb_addr[7:0];
    assign wb_stb      = i_wb_cyc & i_wb_stb;
    assign wb_wr       = wb_stb & i_wb_we;
    assign wb_rd       = wb_stb & ~i_wb_we;
    // A held strobe is one transaction; only its first cycle may push.
    assign wb_push     = wb_wr && (reg_addr == 8'h08) && !prev_stb;
    assign cmd_ready   = ~wb_wr;
    assign cmd_go      = cmd_valid & cmd_ready;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);
    assign irq   = |(flags & int_en);
    assign top   = empty ? '0 : mem[AW'(depth - 1'b1)];
    assign below = (depth < DW'(2)) ? '0 : mem[AW'(depth - DW'(2))];

    // One extra bit so pop-below-zero and push-past-DEPTH never wrap.
    assign depth_ext = {1'b0, depth};
    assign new_depth = depth_ext - (DW+1)'(cmd_pop) + (DW+1)'(cmd_push);
    assign underflow = (DW+1)'(cmd_pop) > depth_ext;
    assign overflow  = !underflow && (new_depth > (DW+1)'(DEPTH));

    assign depth_wr = (i_wb_data > 32'(DEPTH)) ? DW'(DEPTH) : DW'(i_wb_data);
    assign peek_val = (peek_ix < 32'(depth)) ? mem[AW'(32'(depth) - 32'd1 - peek_ix)] : '0;

    always_comb begin
        flag_set    = '0;
        flag_clr    = '0;
        flag_set[0] = cmd_go & underflow;
        flag_set[1] = (cmd_go & overflow) | (wb_push & full);
        if (wb_wr && reg_addr == 8'h0C)
            flag_clr = i_wb_data[1:0];
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr)
            8'h00:   rd_data = 32'(depth);
            8'h04:   rd_data = 32'(top);
            8'h0C:   rd_data = {28'd0, full, empty, flags};
            8'h10:   rd_data = {30'd0, int_en};
            8'h14:   rd_data = peek_ix;
            8'h18:   rd_data = 32'(peek_val);
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            depth     <= '0;
            flags     <= '0;
            int_en    <= '0;
            peek_ix   <= '0;
            prev_stb  <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[AW'(i)] <= '0;
        end else begin
            prev_stb <= wb_stb;
            o_wb_ack <= wb_stb;
            if (wb_rd)
                o_wb_data <= rd_data;
            flags <= (flags & ~flag_clr) | flag_set;
            if (wb_wr) begin
                case (reg_addr)
                    8'h00: depth <= depth_wr;
                    8'h04: if (!empty) mem[AW'(depth - 1'b1)] <= i_wb_data[WIDTH-1:0];
                    8'h08: if (wb_push && !full) begin
                        mem[AW'(depth)] <= i_wb_data[WIDTH-1:0];
                        depth           <= depth + 1'b1;
                    end
                    8'h10: int_en  <= i_wb_data[1:0];
                    8'h14: peek_ix <= i_wb_data;
                    default: ;
                endcase
            end else if (cmd_go && !underflow && !overflow) begin
                depth <= DW'(new_depth);
                if (cmd_push != 2'd0)
                    mem[AW'(new_depth - 1'b1)] <= cmd_top;
                if (cmd_push == 2'd2)
                    mem[AW'(new_depth - (DW+1)'(2))] <= cmd_below;
            end
        end
    end
endmodule
